// File: rtl/lobster_fetch_if.sv
// Fetch-queue bus bundle: SRAM read handshake, executor valid/ready channel and PC redirect.
// master = fetch queue side, slave = SRAM/executor side.
interface lobster_fetch_if #(
   parameter int ADDR_WIDTH = 36
);
   logic                  ce;
   logic [ADDR_WIDTH-1:0] addr_in;
   logic                  rdy;
   logic [63:0]           data_in;
   logic                  out_valid;
   logic [63:0]           out_data;
   logic [ADDR_WIDTH-1:0] out_pc;
   logic                  out_ready;
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_pc;

   modport master (
      output ce, addr_in, out_valid, out_data, out_pc,
      input  rdy, data_in, out_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  ce, addr_in, out_valid, out_data, out_pc,
      output rdy, data_in, out_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/lobster_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues 64-bit SRAM reads and queues bundles.
// Optional statistics counters are enabled with the LOBSTER_FETCH_STATS_EN macro.
module lobster_fetch_queue #(
   parameter int                    ADDR_WIDTH = 36,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 36'hF800
) (
   input  logic            clk,
   input  logic            rst,
   lobster_fetch_if.master bus,
   output logic            busy
`ifdef LOBSTER_FETCH_STATS_EN
   ,
   output logic [31:0]     stat_bundles,
   output logic [31:0]     stat_discards,
   output logic [31:0]     stat_full_cycles
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("lobster_fetch_queue: DEPTH must be a power of two >= 2");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic                  ce_q, ce_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [63:0]           out_data_q, out_data_d;
   logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;

   // NOTE: storage arrays carry no reset; out_valid (from count_q) guards stale contents.
   logic [63:0]           data_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

   logic                  push;
   logic                  pop;
   logic                  discard;
   logic                  space;
   logic                  out_valid;
   logic [PTR_W-1:0]      rd_ptr_inc;
   logic [ADDR_WIDTH-1:0] redirect_target;

   assign out_valid       = (count_q != '0);
   assign space           = (count_q < CNT_W'(DEPTH));
   assign rd_ptr_inc      = rd_ptr_q + PTR_W'(1);
   assign redirect_target = bus.redirect_pc & ~ADDR_WIDTH'(7);
   // Redirect flushes the queue, so a pop on that edge must be suppressed.
   assign pop             = bus.out_ready && out_valid && !bus.redirect_valid;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      ce_d       = ce_q;
      addr_d     = addr_q;
      fetch_pc_d = fetch_pc_q;
      push       = 1'b0;
      discard    = 1'b0;
      unique case (state_q)
         IDLE: begin
            ce_d = 1'b0;
            if (bus.redirect_valid) begin
               fetch_pc_d = redirect_target;
            end else if (space) begin
               ce_d    = 1'b1;
               addr_d  = fetch_pc_q;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.rdy && bus.redirect_valid) begin
               discard    = 1'b1;
               fetch_pc_d = redirect_target;
               ce_d       = 1'b0;
               state_d    = IDLE;
            end else if (bus.rdy) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(8);
               ce_d       = 1'b0;
               state_d    = IDLE;
            end else if (bus.redirect_valid) begin
               // The SRAM cannot abort, so ce stays up and the reply is swallowed in DRAIN.
               fetch_pc_d = redirect_target;
               state_d    = DRAIN;
            end
         end
         DRAIN: begin
            if (bus.redirect_valid) fetch_pc_d = redirect_target;
            if (bus.rdy) begin
               discard = 1'b1;
               ce_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            ce_d    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      out_data_d = out_data_q;
      out_pc_d   = out_pc_q;
      if (bus.redirect_valid) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_inc;
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
         // Head register tracks whichever entry will sit at the head after this edge.
         if (push && (count_q == '0 || (pop && count_q == CNT_W'(1)))) begin
            out_data_d = bus.data_in;
            out_pc_d   = addr_q;
         end else if (pop && count_q > CNT_W'(1)) begin
            out_data_d = data_mem[rd_ptr_inc];
            out_pc_d   = pc_mem[rd_ptr_inc];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; next values come from always_comb.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ce_q       <= 1'b0;
         addr_q     <= '0;
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         out_data_q <= '0;
         out_pc_q   <= '0;
      end else begin
         state_q    <= state_d;
         ce_q       <= ce_d;
         addr_q     <= addr_d;
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         out_data_q <= out_data_d;
         out_pc_q   <= out_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         data_mem[wr_ptr_q] <= bus.data_in;
         pc_mem[wr_ptr_q]   <= addr_q;
      end
   end

   assign bus.ce        = ce_q;
   assign bus.addr_in   = addr_q;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data_q;
   assign bus.out_pc    = out_pc_q;
   assign busy          = (state_q != IDLE);

`ifdef LOBSTER_FETCH_STATS_EN
   logic [31:0] stat_bundles_q, stat_bundles_d;
   logic [31:0] stat_discards_q, stat_discards_d;
   logic [31:0] stat_full_cycles_q, stat_full_cycles_d;

   always_comb begin
      stat_bundles_d     = stat_bundles_q + 32'(push);
      stat_discards_d    = stat_discards_q + 32'(discard);
      stat_full_cycles_d = stat_full_cycles_q + 32'((state_q == IDLE) && !space);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_bundles_q     <= '0;
         stat_discards_q    <= '0;
         stat_full_cycles_q <= '0;
      end else begin
         stat_bundles_q     <= stat_bundles_d;
         stat_discards_q    <= stat_discards_d;
         stat_full_cycles_q <= stat_full_cycles_d;
      end
   end

   assign stat_bundles     = stat_bundles_q;
   assign stat_discards    = stat_discards_q;
   assign stat_full_cycles = stat_full_cycles_q;
`endif

endmodule

// File: tb/tb_lobster_fetch_queue.sv
// Self-checking bench for lobster_fetch_queue: directed scenarios plus random traffic,
// compared every cycle against a transaction-level queue model.
module tb_lobster_fetch_queue;

   localparam int              AW       = 36;
   localparam int              DEPTH    = 4;
   localparam logic [AW-1:0]   RESET_PC = 36'hF800;

   typedef struct {
      logic [AW-1:0] pc;
      logic [63:0]   data;
   } bundle_t;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   always #5 clk = ~clk;

   lobster_fetch_if #(.ADDR_WIDTH(AW)) bus ();

`ifdef LOBSTER_FETCH_STATS_EN
   logic [31:0] stat_bundles;
   logic [31:0] stat_discards;
   logic [31:0] stat_full_cycles;
`endif

   lobster_fetch_queue #(
      .ADDR_WIDTH(AW),
      .DEPTH     (DEPTH),
      .RESET_PC  (RESET_PC)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
`ifdef LOBSTER_FETCH_STATS_EN
      ,
      .stat_bundles    (stat_bundles),
      .stat_discards   (stat_discards),
      .stat_full_cycles(stat_full_cycles)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a queue of bundles plus one optional outstanding request.
   bundle_t       m_q[$];
   logic [AW-1:0] m_fetch_pc;
   bit            m_req_active;
   logic [AW-1:0] m_req_addr;
   bit            m_req_stale;
   int            wait_cnt;
   int            cur_lat;
   int            lat_cfg;
   logic [AW-1:0] issued[$];
   logic          prev_ce;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, input logic [63:0] d, input bit rv,
                             input logic [AW-1:0] rpc, input bit ordy);
      bit            ret;
      bit            was_active;
      int            occ;
      logic [AW-1:0] pc_before;
      ret        = m_req_active && r;
      was_active = m_req_active;
      occ        = m_q.size();
      pc_before  = m_fetch_pc;
      if (rv) begin
         m_q.delete();
         m_fetch_pc = rpc & ~AW'(7);
      end else begin
         if (ordy && occ > 0) void'(m_q.pop_front());
         if (ret && !m_req_stale) begin
            m_q.push_back('{pc: m_req_addr, data: d});
            m_fetch_pc = m_fetch_pc + AW'(8);
         end
      end
      if (ret) m_req_active = 1'b0;
      else if (was_active) begin
         wait_cnt++;
         if (rv) m_req_stale = 1'b1;
      end
      if (!was_active && !rv && occ < DEPTH) begin
         m_req_active = 1'b1;
         m_req_addr   = pc_before;
         m_req_stale  = 1'b0;
         wait_cnt     = 0;
         cur_lat      = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      end
   endtask

   task automatic compare_model();
      check("ce", 64'(bus.ce), 64'(m_req_active));
      check("addr_in", 64'(bus.addr_in), 64'(m_req_addr));
      check("busy", 64'(busy), 64'(m_req_active));
      check("out_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         check("out_pc", 64'(bus.out_pc), 64'(m_q[0].pc));
         check("out_data", bus.out_data, m_q[0].data);
      end
   endtask

   task automatic step(input bit ordy, input bit rv, input logic [AW-1:0] rpc);
      bit          r;
      logic [63:0] d;
      r = m_req_active && (wait_cnt >= cur_lat);
      d = {$urandom, $urandom};
      bus.rdy            = r;
      bus.data_in        = d;
      bus.out_ready      = ordy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      @(posedge clk);
      model_edge(r, d, rv, rpc, ordy);
      #1;
      if (bus.ce && !prev_ce) issued.push_back(bus.addr_in);
      prev_ce = bus.ce;
      compare_model();
   endtask

   task automatic do_reset(input int n, input bit rdy_noise);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         bus.rdy            = rdy_noise;
         bus.data_in        = {$urandom, $urandom};
         bus.out_ready      = 1'b1;
         bus.redirect_valid = 1'b0;
         bus.redirect_pc    = '0;
         @(posedge clk);
         #1;
      end
      rst     = 1'b0;
      bus.rdy = 1'b0;
      m_q.delete();
      m_fetch_pc   = RESET_PC;
      m_req_active = 1'b0;
      m_req_addr   = '0;
      m_req_stale  = 1'b0;
      wait_cnt     = 0;
      cur_lat      = 0;
      prev_ce      = 1'b0;
      issued.delete();
      check("rst_ce", 64'(bus.ce), 64'd0);
      check("rst_addr_in", 64'(bus.addr_in), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", bus.out_data, 64'd0);
      check("rst_out_pc", 64'(bus.out_pc), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
`ifdef LOBSTER_FETCH_STATS_EN
      check("rst_stat_bundles", 64'(stat_bundles), 64'd0);
      check("rst_stat_discards", 64'(stat_discards), 64'd0);
      check("rst_stat_full_cycles", 64'(stat_full_cycles), 64'd0);
`endif
   endtask

   initial begin
      bit found;
      rst                = 1'b1;
      bus.rdy            = 1'b0;
      bus.data_in        = '0;
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      lat_cfg            = 1;

      // Streaming fetch from reset, one-cycle SRAM latency, executor always ready.
      do_reset(2, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
      check("stream_count", 64'(issued.size() >= 3), 64'd1);
      check("stream_addr0", 64'(issued[0]), 64'hF800);
      check("stream_addr1", 64'(issued[1]), 64'hF808);
      check("stream_addr2", 64'(issued[2]), 64'hF810);

      // Executor stalled: the queue fills to DEPTH and issue stops.
      do_reset(1, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0);
      check("full_issue_count", 64'(issued.size()), 64'd4);
      check("full_out_valid", 64'(bus.out_valid), 64'd1);
      check("full_ce", 64'(bus.ce), 64'd0);
      step(1'b1, 1'b0, '0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
      check("refill_issue_count", 64'(issued.size()), 64'd5);
      check("refill_addr", 64'(issued[4]), 64'hF820);

      // Redirect while WAIT; SRAM answers three cycles later and the reply is dropped.
      do_reset(1, 1'b0);
      lat_cfg = 3;
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b1, AW'(36'h12345));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
      check("drain_out_valid", 64'(bus.out_valid), 64'd0);
      check("drain_ce", 64'(bus.ce), 64'd0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
      check("redir_addr", 64'(issued[1]), 64'h12340);
      check("redir_out_pc", 64'(bus.out_pc), 64'h12340);

      // rdy and redirect on the same edge with two bundles queued.
      do_reset(1, 1'b0);
      lat_cfg = 1;
      found   = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (m_q.size() == 2 && m_req_active && wait_cnt >= cur_lat) found = 1'b1;
         else step(1'b0, 1'b0, '0);
      end
      check("sameedge_setup", 64'(found), 64'd1);
      step(1'b0, 1'b1, AW'(36'h100));
      check("sameedge_out_valid", 64'(bus.out_valid), 64'd0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
      check("sameedge_next_addr", 64'(issued[3]), 64'h100);

      // Redirect to the top bundle: the fetch PC wraps to zero.
      do_reset(1, 1'b0);
      step(1'b1, 1'b1, AW'(36'hFFFFFFFF8));
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
      check("wrap_addr0", 64'(issued[0]), 64'hFFFFFFFF8);
      check("wrap_addr1", 64'(issued[1]), 64'h0);

      // Random traffic: variable latency, random executor stalls and redirects.
      do_reset(1, 1'b0);
      lat_cfg = -1;
      for (int i = 0; i < 600; i++) begin
         logic [63:0] t;
         t = {$urandom, $urandom};
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0), t[AW-1:0]);
      end

      // Reset asserted mid-request with rdy arriving during reset.
      do_reset(1, 1'b0);
      lat_cfg = 6;
      step(1'b1, 1'b0, '0);
      check("midrst_in_wait", 64'(busy), 64'd1);
      do_reset(2, 1'b1);
      lat_cfg = 1;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
      check("midrst_first_addr", 64'(issued[0]), 64'hF800);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
